// File: rtl/usb_reg_bridge.sv
// rtl/usb_reg_bridge.sv - host byte-stream decoder for multi-byte register access and FIFO streaming
//
// Frame: header {1, wr, addr[5:0]}, length L (0 = 256), then L data bytes on writes.
// Writes assemble a shadow register and commit it atomically; reads snapshot a whole
// register before sending it LSB first; reads of STREAM_ADDR drain up to L FIFO entries.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   tx_data, tx_start   byte to send and its one-cycle request; tx_busy from the transmitter
//   reg_out, reg_wr_stb flat writable register bus and per-register commit pulse
//   reg_in              read-only register sources, same layout as reg_out
//   fifo_empty, fifo_data, fifo_rd_en  ADC FIFO read side (data valid one cycle after rd_en)
//   err_timeout         one-cycle pulse when a stalled command is aborted
//
// Optional feature macro: USB_CMD_TIMEOUT_EN (idle-receive abort after TIMEOUT_CYCLES).

module usb_reg_bridge #(
    parameter int                  NUM_REGS       = 16,
    parameter int                  REG_BYTES      = 4,
    parameter int                  STREAM_ADDR    = 3,
    parameter logic [NUM_REGS-1:0] RO_MASK        = 16'h0004,
    parameter logic [7:0]          PAD_BYTE       = 8'hAC,
    parameter int                  TIMEOUT_CYCLES = 1000000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic [7:0]                      tx_data,
    output logic                            tx_start,
    input  logic                            tx_busy,
    output logic [NUM_REGS*REG_BYTES*8-1:0] reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_stb,
    input  logic [NUM_REGS*REG_BYTES*8-1:0] reg_in,
    input  logic                            fifo_empty,
    input  logic [7:0]                      fifo_data,
    output logic                            fifo_rd_en,
    output logic                            err_timeout
);

    localparam int             RW       = REG_BYTES * 8;
    localparam int             OW       = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;
    localparam logic [OW-1:0]  OFF_LAST = OW'(REG_BYTES - 1);
    localparam logic [63:0]    RO_EXT   = 64'(RO_MASK);
    localparam logic [5:0]     STREAM_A = 6'(STREAM_ADDR);

    typedef enum logic [3:0] {
        IDLE, LEN, WR_DATA, RD_LOAD, RD_SEND, RD_WAIT, ST_FETCH, ST_SEND, ST_WAIT
    } state_t;

    state_t        state;
    logic          is_wr;
    logic [5:0]    addr;
    logic [OW-1:0] off;
    logic [8:0]    cnt;
    logic [RW-1:0] shadow;
    logic [RW-1:0] snap;
    logic          popped;
    logic          guard;

    logic          mapped;
    logic          writable;
    logic [5:0]    idx;
    logic [5:0]    addr_next;
    logic          tx_ready;
    int            base;
    int            boff;
    logic [RW-1:0] src_word;
    logic [RW-1:0] wr_word;

    assign mapped    = (int'(addr) < NUM_REGS);
    assign writable  = mapped && !RO_EXT[addr] && (addr != STREAM_A);
    // idx stays in range for unmapped addresses so the part-selects below never overrun
    assign idx       = mapped ? addr : 6'd0;
    assign addr_next = (addr == 6'h3F) ? addr : addr + 6'd1;
    // the transmitter may not have raised busy yet in the two cycles after a start
    assign tx_ready  = !tx_start && !guard && !tx_busy;

    always_comb begin
        base = int'(idx) * RW;
        boff = int'(off) * 8;
    end

    always_comb begin
        src_word = {REG_BYTES{PAD_BYTE}};
        if (mapped) begin
            src_word = RO_EXT[addr] ? reg_in[base +: RW] : reg_out[base +: RW];
        end
    end

    always_comb begin
        wr_word = shadow;
        wr_word[boff +: 8] = rx_data;
    end

`ifdef USB_CMD_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
    logic          err_q;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            addr       <= '0;
            off        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            snap       <= '0;
            popped     <= 1'b0;
            guard      <= 1'b0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            fifo_rd_en <= 1'b0;
            reg_out    <= '0;
            reg_wr_stb <= '0;
`ifdef USB_CMD_TIMEOUT_EN
            tcnt       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            tx_start   <= 1'b0;
            fifo_rd_en <= 1'b0;
            reg_wr_stb <= '0;
            guard      <= tx_start;
            case (state)
                IDLE: begin
                    if (rx_valid && rx_data[7]) begin
                        is_wr <= rx_data[6];
                        addr  <= rx_data[5:0];
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        cnt    <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        off    <= '0;
                        shadow <= '0;
                        if (is_wr)                 state <= WR_DATA;
                        else if (addr == STREAM_A) state <= ST_FETCH;
                        else                       state <= RD_LOAD;
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        cnt <= cnt - 9'd1;
                        if (off == OFF_LAST) begin
                            // whole register assembled: publish it in a single cycle
                            if (writable) begin
                                reg_out[base +: RW] <= wr_word;
                                reg_wr_stb          <= NUM_REGS'(1) << idx;
                            end
                            off    <= '0;
                            shadow <= '0;
                            addr   <= addr_next;
                        end else begin
                            off    <= off + OW'(1);
                            shadow <= wr_word;
                        end
                        if (cnt == 9'd1) state <= IDLE;
                    end
                end
                RD_LOAD: begin
                    snap  <= src_word;
                    state <= RD_SEND;
                end
                RD_SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= snap[boff +: 8];
                        tx_start <= 1'b1;
                        cnt      <= cnt - 9'd1;
                        if (off == OFF_LAST) begin
                            off  <= '0;
                            addr <= addr_next;
                        end else begin
                            off <= off + OW'(1);
                        end
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (tx_ready) begin
                        if (cnt == 9'd0)     state <= IDLE;
                        else if (off == '0)  state <= RD_LOAD;
                        else                 state <= RD_SEND;
                    end
                end
                ST_FETCH: begin
                    fifo_rd_en <= !fifo_empty;
                    popped     <= !fifo_empty;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    // while fifo_rd_en is high the popped entry is not on fifo_data yet
                    if (!fifo_rd_en && !tx_busy) begin
                        tx_data  <= popped ? fifo_data : PAD_BYTE;
                        tx_start <= 1'b1;
                        cnt      <= cnt - 9'd1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tx_ready) state <= (cnt == 9'd0) ? IDLE : ST_FETCH;
                end
                default: state <= IDLE;
            endcase
`ifdef USB_CMD_TIMEOUT_EN
            err_q <= 1'b0;
            if (rx_valid || !(state == LEN || state == WR_DATA)) begin
                tcnt <= '0;
            end else if (tcnt == TO_LAST) begin
                state  <= IDLE;
                shadow <= '0;
                err_q  <= 1'b1;
                tcnt   <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_usb_reg_bridge.sv
// tb/tb_usb_reg_bridge.sv - self-checking bench for usb_reg_bridge

module tb_usb_reg_bridge;

    localparam int NR = 16;
    localparam int RW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [NR*RW-1:0]  reg_out;
    logic [NR-1:0]     reg_wr_stb;
    logic [NR*RW-1:0]  reg_in = '0;
    logic              fifo_empty;
    logic [7:0]        fifo_data = 8'd0;
    logic              fifo_rd_en;
    logic              err_timeout;

    always #5 clk = ~clk;

    usb_reg_bridge #(.TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .reg_out    (reg_out),
        .reg_wr_stb (reg_wr_stb),
        .reg_in     (reg_in),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .err_timeout(err_timeout)
    );

    // transmitter model: busy for 3 cycles after each accepted start
    int busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= 3;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // FIFO model: registered read data
    logic [7:0] fifo_arr [8];
    int         rd_ptr = 0;
    int         wr_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= fifo_arr[rd_ptr[2:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // output monitor
    logic [7:0]       act_q [$];
    logic [7:0]       exp_q [$];
    int               stb_cnt [NR];
    int               busy_viol = 0;
    int               part_viol = 0;
    int               err_cnt = 0;
    logic             rst_q = 1'b0;
    logic [NR*RW-1:0] prev_reg = '0;

    initial for (int i = 0; i < NR; i++) stb_cnt[i] = 0;

    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin
        if (tx_start) begin
            act_q.push_back(tx_data);
            if (tx_busy) busy_viol++;
        end
        if (err_timeout) err_cnt++;
        for (int i = 0; i < NR; i++) begin
            if (reg_wr_stb[i]) stb_cnt[i]++;
            if (rst_q && reg_out[i*RW +: RW] != prev_reg[i*RW +: RW] && !reg_wr_stb[i]) part_viol++;
        end
        prev_reg = reg_out;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int t = 0;
        logic [7:0] a, e;
        while (exp_q.size() != 0 && t < budget) begin
            if (act_q.size() != 0) begin
                a = act_q.pop_front();
                e = exp_q.pop_front();
                check(name, a, e);
            end else begin
                @(negedge clk);
                t++;
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=%0d_bytes_missing required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (20) @(negedge clk);
        check({name, "_extra"}, act_q.size(), 0);
        act_q.delete();
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [7:0]  len;
        logic [63:0] data;     // write payload, or expected tx bytes for reads (LSB first)
        int          kind;     // 0: write, check one register; 1: write, check total strobes; 2: read
        int          reg_i;
        logic [31:0] exp_val;
        int          exp_stb;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int s0 [NR];
        int tot0, tot1;

        vecs[0]  = '{8'hC5, 8'd4, 64'h44332211,         0, 5,  32'h44332211, 1};
        vecs[1]  = '{8'hC0, 8'd6, 64'h060504030201,     0, 0,  32'h04030201, 1};
        vecs[2]  = '{8'h81, 8'd4, 64'h0,                2, 0,  32'h0,        0};
        vecs[3]  = '{8'h85, 8'd4, 64'h44332211,         2, 0,  32'h0,        0};
        vecs[4]  = '{8'hC6, 8'd8, 64'hCAFEF00D12345678, 0, 7,  32'hCAFEF00D, 1};
        vecs[5]  = '{8'h86, 8'd2, 64'h5678,             2, 0,  32'h0,        0};
        vecs[6]  = '{8'hC2, 8'd4, 64'hFFFFFFFF,         1, 0,  32'h0,        0};
        vecs[7]  = '{8'hC3, 8'd4, 64'h55667788,         1, 0,  32'h0,        0};
        vecs[8]  = '{8'hE0, 8'd4, 64'h99AABBCC,         1, 0,  32'h0,        0};
        vecs[9]  = '{8'hCF, 8'd4, 64'h87654321,         0, 15, 32'h87654321, 1};
        vecs[10] = '{8'h84, 8'd6, 64'h221100000000,     2, 0,  32'h0,        0};
        vecs[11] = '{8'h8F, 8'd8, 64'hACACACAC87654321, 2, 0,  32'h0,        0};
        vecs[12] = '{8'h80, 8'd2, 64'h0201,             2, 0,  32'h0,        0};

        reg_in[2*RW +: RW] = 32'hDEADBEEF;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_reg_out_zero", (reg_out == '0), 1);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_reg_wr_stb", reg_wr_stb, 0);
        check("rst_err_timeout", err_timeout, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].kind == 2) begin
                for (int b = 0; b < int'(vecs[v].len); b++) exp_q.push_back(vecs[v].data[8*b +: 8]);
                send_byte(vecs[v].hdr);
                send_byte(vecs[v].len);
                drain($sformatf("vec%0d_tx", v), 400);
            end else begin
                for (int i = 0; i < NR; i++) s0[i] = stb_cnt[i];
                send_byte(vecs[v].hdr);
                send_byte(vecs[v].len);
                for (int b = 0; b < int'(vecs[v].len); b++) send_byte(vecs[v].data[8*b +: 8]);
                repeat (3) @(negedge clk);
                if (vecs[v].kind == 0) begin
                    check($sformatf("vec%0d_reg", v), reg_out[vecs[v].reg_i*RW +: RW], vecs[v].exp_val);
                    check($sformatf("vec%0d_stb", v), stb_cnt[vecs[v].reg_i] - s0[vecs[v].reg_i], vecs[v].exp_stb);
                end else begin
                    tot0 = 0;
                    tot1 = 0;
                    for (int i = 0; i < NR; i++) begin
                        tot0 += s0[i];
                        tot1 += stb_cnt[i];
                    end
                    check($sformatf("vec%0d_no_stb", v), tot1 - tot0, vecs[v].exp_stb);
                end
            end
        end
        check("partial_reg1_no_stb", stb_cnt[1], 0);
        check("partial_reg1_value", reg_out[1*RW +: RW], 0);
        check("ro_reg2_untouched", reg_out[2*RW +: RW], 0);
        check("stream_reg3_untouched", reg_out[3*RW +: RW], 0);

        // read-only snapshot: source changes after the first byte leaves
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
        send_byte(8'h82);
        send_byte(8'h04);
        for (int t = 0; t < 200 && act_q.size() == 0; t++) @(negedge clk);
        reg_in[2*RW +: RW] = 32'h0;
        drain("ro_snapshot", 400);

        // stream: 3 entries, 5 requested; a byte arriving mid-read is dropped
        fifo_arr[0] = 8'hA1; fifo_arr[1] = 8'hA2; fifo_arr[2] = 8'hA3;
        wr_ptr = 3;
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        exp_q.push_back(8'hAC); exp_q.push_back(8'hAC);
        send_byte(8'h83);
        send_byte(8'h05);
        send_byte(8'hC0);
        drain("stream_tx", 400);
        check("stream_pops", rd_ptr, 3);

        // header without bit7 is ignored
        exp_q.push_back(8'h11);
        send_byte(8'h45);
        send_byte(8'h85);
        send_byte(8'h01);
        drain("ignored_hdr", 400);

        // L=0 means 256 bytes, unmapped address pads
        for (int b = 0; b < 256; b++) exp_q.push_back(8'hAC);
        send_byte(8'h9F);
        send_byte(8'h00);
        drain("len256_tx", 4000);

        // reset mid-frame
        send_byte(8'hC8);
        send_byte(8'h04);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_reg_out_zero", (reg_out == '0), 1);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h00);
        send_byte(8'h88);
        send_byte(8'h04);
        drain("midrst_read", 400);

`ifdef USB_CMD_TIMEOUT_EN
        begin
            int e0;
            e0 = err_cnt;
            for (int i = 0; i < NR; i++) s0[i] = stb_cnt[i];
            send_byte(8'hC1);
            send_byte(8'h04);
            send_byte(8'h01);
            send_byte(8'h02);
            repeat (150) @(negedge clk);
            check("timeout_err_pulse", err_cnt - e0, 1);
            check("timeout_reg1_no_stb", stb_cnt[1] - s0[1], 0);
            exp_q.push_back(8'h00);
            send_byte(8'h81);
            send_byte(8'h01);
            drain("timeout_recover", 400);
        end
`else
        check("err_timeout_never", err_cnt, 0);
`endif

        check("tx_start_while_busy", busy_viol, 0);
        check("reg_change_without_stb", part_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
